// File: rtl/arch_reg_file_if.sv
// Commit, allocate and operand-read bundle of the architectural register file.
// master: commit queue plus dispatch side; slave: the register file itself.
interface arch_reg_file_if #(
    parameter int N_REG  = 64,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
);
    localparam int AW = $clog2(N_REG);

    logic              commit_en;
    logic [AW-1:0]     commit_dest;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;
    logic              commit_reject;

    logic              alloc_en;
    logic [AW-1:0]     alloc_dest;
    logic [TAG_W-1:0]  alloc_tag;
    logic              alloc_reject;

    logic              flush;

    logic [AW-1:0]     rd0_addr;
    logic [AW-1:0]     rd1_addr;
    logic [DATA_W-1:0] rd0_data;
    logic [DATA_W-1:0] rd1_data;
    logic              rd0_busy;
    logic              rd1_busy;
    logic [TAG_W-1:0]  rd0_tag;
    logic [TAG_W-1:0]  rd1_tag;

    logic [AW:0]       n_busy;
    logic              ready;

    modport master (
        output commit_en, commit_dest, commit_tag, commit_data,
        output alloc_en, alloc_dest, alloc_tag, flush,
        output rd0_addr, rd1_addr,
        input  commit_reject, alloc_reject,
        input  rd0_data, rd1_data, rd0_busy, rd1_busy,
        input  rd0_tag, rd1_tag, n_busy, ready
    );

    modport slave (
        input  commit_en, commit_dest, commit_tag, commit_data,
        input  alloc_en, alloc_dest, alloc_tag, flush,
        input  rd0_addr, rd1_addr,
        output commit_reject, alloc_reject,
        output rd0_data, rd1_data, rd0_busy, rd1_busy,
        output rd0_tag, rd1_tag, n_busy, ready
    );
endinterface

// File: rtl/arch_reg_file.sv
// Architectural register file with per-register pending-writer scoreboard.
// Ports: clock, reset (sync, active-high), bus (arch_reg_file_if.slave).
module arch_reg_file #(
    parameter int N_REG  = 64,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic            clock,
    input  logic            reset,
    arch_reg_file_if.slave  bus
);
    localparam int AW = $clog2(N_REG);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     idx;
    logic [N_REG-1:0]  busy;
    logic [AW:0]       n_busy_q;
    logic [DATA_W-1:0] regs [N_REG];
    logic [TAG_W-1:0]  tags [N_REG];

    logic run;
    logic commit_wr;
    logic clr;
    logic alloc_wr;
    logic inc;
    logic dec;

    assign run = (state == ST_RUN);

    assign commit_wr = run && bus.commit_en
                     && (bus.commit_dest != '0);

    // The committing entry only retires the scoreboard mark if it
    // is still the youngest writer of that register.
    assign clr = commit_wr && busy[bus.commit_dest]
               && (tags[bus.commit_dest] == bus.commit_tag);

    assign alloc_wr = run && bus.alloc_en && !bus.flush
                    && (bus.alloc_dest != '0);

    // An alloc landing on the register being cleared keeps it busy,
    // so that clear must not be counted down.
    assign inc = alloc_wr && !busy[bus.alloc_dest];
    assign dec = clr && !(alloc_wr
               && (bus.alloc_dest == bus.commit_dest));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_INIT;
            idx      <= '0;
            busy     <= '0;
            n_busy_q <= '0;
        end else if (!run) begin
            idx <= idx + AW'(1);
            if (idx == AW'(N_REG - 1))
                state <= ST_RUN;
        end else if (bus.flush) begin
            busy     <= '0;
            n_busy_q <= '0;
        end else begin
            if (clr)
                busy[bus.commit_dest] <= 1'b0;
            // Later assignment: allocation wins over the clear.
            if (alloc_wr)
                busy[bus.alloc_dest] <= 1'b1;
            n_busy_q <= n_busy_q + (AW+1)'(inc)
                                 - (AW+1)'(dec);
        end
    end

    // Storage is cleared by the INIT walk rather than by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!run) begin
                regs[idx] <= '0;
                tags[idx] <= '0;
            end else begin
                if (commit_wr)
                    regs[bus.commit_dest] <= bus.commit_data;
                if (alloc_wr)
                    tags[bus.alloc_dest] <= bus.alloc_tag;
            end
        end
    end

    logic rd0_hit;
    logic rd1_hit;
    logic rd0_nz;
    logic rd1_nz;

    assign rd0_nz  = run && (bus.rd0_addr != '0);
    assign rd1_nz  = run && (bus.rd1_addr != '0);
    assign rd0_hit = bus.commit_dest == bus.rd0_addr;
    assign rd1_hit = bus.commit_dest == bus.rd1_addr;

    assign bus.rd0_data =
        !rd0_nz              ? '0 :
        (commit_wr && rd0_hit) ? bus.commit_data :
                               regs[bus.rd0_addr];
    assign bus.rd1_data =
        !rd1_nz              ? '0 :
        (commit_wr && rd1_hit) ? bus.commit_data :
                               regs[bus.rd1_addr];

    assign bus.rd0_busy = rd0_nz && busy[bus.rd0_addr]
                        && !(clr && rd0_hit);
    assign bus.rd1_busy = rd1_nz && busy[bus.rd1_addr]
                        && !(clr && rd1_hit);

    assign bus.rd0_tag = rd0_nz ? tags[bus.rd0_addr] : '0;
    assign bus.rd1_tag = rd1_nz ? tags[bus.rd1_addr] : '0;

    assign bus.commit_reject = !run;
    assign bus.alloc_reject  = !run;
    assign bus.n_busy        = n_busy_q;
    assign bus.ready         = run;
endmodule
